// File: rtl/tc_pkg.sv
// Shared light encodings, state codes and direction constants for the intersection scheduler.
package tc_pkg;

   localparam logic [2:0] LT_RED = 3'b100;
   localparam logic [2:0] LT_YEL = 3'b010;
   localparam logic [2:0] LT_GRN = 3'b001;

   typedef enum logic [2:0] {
      S_AG  = 3'd0,
      S_AY  = 3'd1,
      S_RR  = 3'd2,
      S_PED = 3'd3,
      S_BG  = 3'd4,
      S_BY  = 3'd5
   } state_e;

   typedef enum logic {
      DIR_A = 1'b0,
      DIR_B = 1'b1
   } dir_e;

endpackage

// File: rtl/tc_phase_timer.sv
// Phase tick counter: synchronous clear wins over enable, counts saturate at all-ones.
// t_o is one wider than the count so that count+1 never wraps.
module tc_phase_timer #(
   parameter int CNT_W = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic [CNT_W:0]   t_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;
   assign t_o   = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

endmodule

// File: rtl/tc_timed_scheduler.sv
// Timed two-road intersection scheduler (Moore): min/max green, yellow, all-red, optional WALK.
// Exits are evaluated only on en_i ticks; lights decode purely from the state register.
module tc_timed_scheduler
   import tc_pkg::*;
#(
   parameter int GREEN_MIN = 3,
   parameter int GREEN_MAX = 8,
   parameter int YELLOW_T  = 2,
   parameter int ALLRED_T  = 1,
   parameter int PED_T     = 4,
   parameter int CNT_W     = 4
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       en_i,
   input  logic       t_a_i,
   input  logic       t_b_i,
   input  logic       p_req_i,
   output logic [2:0] l_a_o,
   output logic [2:0] l_b_o,
   output logic       walk_o,
   output logic [2:0] state_o
);

   // Green limits compare against the raw count: count >= N-1 means this tick is the N-th.
   localparam logic [CNT_W-1:0] GMIN_M1 = CNT_W'(GREEN_MIN - 1);
   localparam logic [CNT_W-1:0] GMAX_M1 = CNT_W'(GREEN_MAX - 1);
   localparam logic [CNT_W:0]   YEL_C   = (CNT_W+1)'(YELLOW_T);
   localparam logic [CNT_W:0]   ARED_C  = (CNT_W+1)'(ALLRED_T);
   localparam logic [CNT_W:0]   PED_C   = (CNT_W+1)'(PED_T);

   state_e state_q, state_d;
   dir_e   next_dir_q, next_dir_d;
   logic   ped_pend_q, ped_pend_d;
   logic   state_chg;

   logic [CNT_W-1:0] timer_cnt;
   logic [CNT_W:0]   t;
   logic             min_ok, max_ok;

   assign min_ok = (timer_cnt >= GMIN_M1);
   assign max_ok = (timer_cnt >= GMAX_M1);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_AG:  if (en_i && (t_b_i || ped_pend_q) && ((min_ok && !t_a_i) || max_ok)) state_d = S_AY;
         S_BG:  if (en_i && (t_a_i || ped_pend_q) && ((min_ok && !t_b_i) || max_ok)) state_d = S_BY;
         S_AY,
         S_BY:  if (en_i && (t == YEL_C)) state_d = S_RR;
         S_RR: begin
            if (en_i && (t == ARED_C)) begin
               if (ped_pend_q)                state_d = S_PED;
               else if (next_dir_q == DIR_A) state_d = S_AG;
               else                          state_d = S_BG;
            end
         end
         S_PED: if (en_i && (t == PED_C)) state_d = (next_dir_q == DIR_A) ? S_AG : S_BG;
         default: state_d = S_AG;
      endcase
   end

   assign state_chg = (state_d != state_q);

   always_comb begin
      ped_pend_d = ped_pend_q;
      next_dir_d = next_dir_q;
      if (p_req_i && (state_q != S_PED)) ped_pend_d = 1'b1;
      // Entering PED consumes the request that selected it; a press on that same edge is dropped.
      if (state_chg && (state_d == S_PED)) ped_pend_d = 1'b0;
      if (state_chg && (state_d == S_AY))  next_dir_d = DIR_B;
      if (state_chg && (state_d == S_BY))  next_dir_d = DIR_A;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= S_AG;
         ped_pend_q <= 1'b0;
         next_dir_q <= DIR_B;
      end else begin
         state_q    <= state_d;
         ped_pend_q <= ped_pend_d;
         next_dir_q <= next_dir_d;
      end
   end

   tc_phase_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (state_chg),
      .en_i   (en_i),
      .cnt_o  (timer_cnt),
      .t_o    (t)
   );

   always_comb begin
      l_a_o = LT_RED;
      l_b_o = LT_RED;
      if (state_q == S_AG) l_a_o = LT_GRN;
      if (state_q == S_AY) l_a_o = LT_YEL;
      if (state_q == S_BG) l_b_o = LT_GRN;
      if (state_q == S_BY) l_b_o = LT_YEL;
   end

   assign walk_o  = (state_q == S_PED);
   assign state_o = state_q;

endmodule

// File: tb/tb_tc_timed_scheduler.sv
// Scoreboard bench: each clock edge the phase model pushes the expected lights; a negedge monitor pops and compares.
module tb_tc_timed_scheduler;
   import tc_pkg::*;

   localparam int GREEN_MIN = 3;
   localparam int GREEN_MAX = 8;
   localparam int YELLOW_T  = 2;
   localparam int ALLRED_T  = 1;
   localparam int PED_T     = 4;
   localparam int EL_SAT    = 15;

   localparam int P_AG = 0, P_AY = 1, P_RR = 2, P_PED = 3, P_BG = 4, P_BY = 5;

   typedef struct packed {
      logic [2:0] la;
      logic [2:0] lb;
      logic       w;
      logic [2:0] st;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n, en, ta, tb, preq;
   logic [2:0] l_a, l_b, state;
   logic walk;

   always #5 clk = ~clk;

   tc_timed_scheduler dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .en_i    (en),
      .t_a_i   (ta),
      .t_b_i   (tb),
      .p_req_i (preq),
      .l_a_o   (l_a),
      .l_b_o   (l_b),
      .walk_o  (walk),
      .state_o (state)
   );

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   pushes = 0;

   // reference model: current phase, ticks spent in it, pending walk request, next green road
   int ph, el;
   bit pend, go_b;

   exp_t E_AG, E_AY, E_RR, E_PED, E_BG, E_BY;

   function automatic exp_t mk(logic [2:0] la, logic [2:0] lb, logic w, logic [2:0] st);
      exp_t e;
      e.la = la; e.lb = lb; e.w = w; e.st = st;
      return e;
   endfunction

   function automatic exp_t expect_now();
      case (ph)
         P_AG:    return E_AG;
         P_AY:    return E_AY;
         P_RR:    return E_RR;
         P_PED:   return E_PED;
         P_BG:    return E_BG;
         default: return E_BY;
      endcase
   endfunction

   task automatic chk(string nm, exp_t e);
      exp_t act;
      act = {l_a, l_b, walk, state};
      n_cmp++;
      if (act !== e) begin
         n_bad++;
         $display("FAIL %s: got la=%b lb=%b walk=%b st=%0d, expected la=%b lb=%b walk=%b st=%0d",
                  nm, act.la, act.lb, act.w, act.st, e.la, e.lb, e.w, e.st);
      end
   endtask

   task automatic model_reset();
      ph = P_AG; el = 0; pend = 1'b0; go_b = 1'b1;
   endtask

   task automatic model_step(bit en_b, bit a, bit b, bit pr);
      int nph, t;
      nph = ph;
      t   = el + 1;
      if (en_b) begin
         case (ph)
            P_AG:  if ((b || pend) && ((t >= GREEN_MIN && !a) || t >= GREEN_MAX)) nph = P_BY - 4;
            P_BG:  if ((a || pend) && ((t >= GREEN_MIN && !b) || t >= GREEN_MAX)) nph = P_BY;
            P_AY, P_BY: if (t == YELLOW_T) nph = P_RR;
            P_RR:  if (t == ALLRED_T) nph = pend ? P_PED : (go_b ? P_BG : P_AG);
            P_PED: if (t == PED_T) nph = go_b ? P_BG : P_AG;
            default: nph = P_AG;
         endcase
      end
      if (pr && ph != P_PED) pend = 1'b1;
      if (nph != ph) begin
         el = 0;
         if (nph == P_PED) pend = 1'b0;
         if (nph == P_AY)  go_b = 1'b1;
         if (nph == P_BY)  go_b = 1'b0;
      end else if (en_b && el < EL_SAT) begin
         el++;
      end
      ph = nph;
   endtask

   // One clock edge: model consumes the inputs the DUT saw, expectation queued, inputs may change after.
   task automatic tick();
      @(posedge clk);
      if (!rst_n) model_reset();
      else        model_step(en, ta, tb, preq);
      exp_q.push_back(expect_now());
      pushes++;
      #1;
   endtask

   // Asynchronous reset pulse starting mid-cycle; outputs must return to AG before any edge.
   task automatic pulse_reset(bit check_now);
      #1;
      rst_n = 1'b0;
      model_reset();
      exp_q.delete();
      if (pushes > 0) exp_q.push_back(expect_now());
      #1;
      if (check_now) chk("async_reset", E_AG);
      tick();
      rst_n = 1'b1;
   endtask

   task automatic restart();
      {ta, tb, preq} = 3'b000;
      en = 1'b1;
      pulse_reset(1'b0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() == 0) begin
            if (pushes > 0) begin
               n_cmp++; n_bad++;
               $display("FAIL scoreboard_empty: got no expectation, required one per edge");
            end
         end else begin
            e = exp_q.pop_front();
            chk("scoreboard", e);
         end
      end
   end

   initial begin : stim
      E_AG  = mk(3'b001, 3'b100, 1'b0, S_AG);
      E_AY  = mk(3'b010, 3'b100, 1'b0, S_AY);
      E_RR  = mk(3'b100, 3'b100, 1'b0, S_RR);
      E_PED = mk(3'b100, 3'b100, 1'b1, S_PED);
      E_BG  = mk(3'b100, 3'b001, 1'b0, S_BG);
      E_BY  = mk(3'b100, 3'b010, 1'b0, S_BY);

      rst_n = 1'b0; en = 1'b1; {ta, tb, preq} = 3'b000;
      model_reset();
      #2 chk("reset_state", E_AG);
      tick();
      tick();
      rst_n = 1'b1;

      // no traffic: AG forever
      for (int e = 1; e <= 20; e++) begin
         tick();
         if (e == 1 || e == 20) chk("idle_hold", E_AG);
      end

      // only road B: AG 3, AY 2, RR 1, BG
      restart();
      tb = 1'b1;
      for (int e = 1; e <= 7; e++) begin
         tick();
         if (e == 2) chk("b_only_e2", E_AG);
         if (e == 3) chk("b_only_e3", E_AY);
         if (e == 5) chk("b_only_e5", E_RR);
         if (e == 6) chk("b_only_e6", E_BG);
      end

      // both roads busy: alternate at GREEN_MAX
      restart();
      {ta, tb} = 2'b11;
      for (int e = 1; e <= 40; e++) begin
         tick();
         if (e == 7)  chk("both_e7",  E_AG);
         if (e == 8)  chk("both_e8",  E_AY);
         if (e == 10) chk("both_e10", E_RR);
         if (e == 11) chk("both_e11", E_BG);
         if (e == 18) chk("both_e18", E_BG);
         if (e == 19) chk("both_e19", E_BY);
         if (e == 21) chk("both_e21", E_RR);
         if (e == 22) chk("both_e22", E_AG);
         if (e == 30) chk("both_e30", E_AY);
      end

      // pedestrian press while A busy: forced at GREEN_MAX, WALK, then B, no second WALK
      restart();
      ta = 1'b1;
      for (int e = 1; e <= 24; e++) begin
         preq = (e == 2);
         tick();
         if (e == 7)  chk("ped_e7",  E_AG);
         if (e == 8)  chk("ped_e8",  E_AY);
         if (e == 11) chk("ped_e11", E_PED);
         if (e == 14) chk("ped_e14", E_PED);
         if (e == 15) chk("ped_e15", E_BG);
         if (e == 18) chk("ped_e18", E_BY);
         if (e == 21) chk("ped_e21", E_AG);
      end
      preq = 1'b0;

      // tick every other clock: every phase doubles
      restart();
      tb = 1'b1;
      for (int e = 1; e <= 12; e++) begin
         en = e[0];
         tick();
         if (e == 4)  chk("half_e4",  E_AG);
         if (e == 5)  chk("half_e5",  E_AY);
         if (e == 8)  chk("half_e8",  E_AY);
         if (e == 9)  chk("half_e9",  E_RR);
         if (e == 11) chk("half_e11", E_BG);
      end
      en = 1'b1;

      // reset during the second AY cycle: immediate AG, timer restarts from zero
      restart();
      tb = 1'b1;
      for (int e = 1; e <= 4; e++) tick();
      chk("pre_reset_ay", E_AY);
      pulse_reset(1'b1);
      for (int e = 1; e <= 3; e++) begin
         tick();
         if (e == 2) chk("post_reset_e2", E_AG);
         if (e == 3) chk("post_reset_e3", E_AY);
      end

      // random traffic, ticks, presses and occasional resets
      restart();
      for (int i = 0; i < 4000; i++) begin
         en   = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 9) == 0) ta = ~ta;
         if ($urandom_range(0, 9) == 0) tb = ~tb;
         preq = ($urandom_range(0, 24) == 0);
         if ($urandom_range(0, 499) == 0) pulse_reset(1'b1);
         else tick();
      end

      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
